// File: rtl/snake_collision_scanner.sv
// Purpose: time-shares one 20-bit equality comparator to run the head-vs-food and head-vs-body checks for each snake move.
// Latency: done pulses 2 cycles after accept for an empty body, N+2 cycles for N segments, k+3 cycles for a first hit at segment k.
// Backpressure: no queuing; start is only accepted in IDLE or DONE and is ignored while busy.
module snake_collision_scanner #(
    parameter int MAX_LEN = 64,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [19:0]       head_pos,
    input  logic [19:0]       food_pos,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] seg_addr,
    output logic              seg_rd_en,
    input  logic [19:0]       seg_data,
    output logic [19:0]       cmp_a,
    output logic [19:0]       cmp_b,
    input  logic              cmp_eq,
    output logic              busy,
    output logic              done,
    output logic              food_hit,
    output logic              self_hit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOOD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    // MAX_LEN expressed in the width of the length bus, for clamping.
    localparam logic [ADDR_W:0] MAX_L = (ADDR_W+1)'(MAX_LEN);

    state_t          state;
    state_t          state_nxt;
    logic [19:0]     head_r;
    logic [19:0]     food_r;
    logic [ADDR_W:0] len_r;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] idx_p1;
    logic            accept;
    logic            idx_inc;
    logic            self_set;

    // idx is one bit wider than the address so idx+1 can be compared against len_r without wrapping.
    assign idx_p1 = idx + 1'b1;
    assign busy   = (state == FOOD) || (state == SCAN);
    assign done   = (state == DONE);

    // Next state, comparator operands and RAM read strobe; all decided from the current state and registers.
    always_comb begin
        state_nxt = state;
        seg_rd_en = 1'b0;
        seg_addr  = '0;
        cmp_a     = 20'd0;
        cmp_b     = 20'd0;
        accept    = 1'b0;
        idx_inc   = 1'b0;
        self_set  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = FOOD;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            FOOD: begin
                cmp_a = head_r;
                cmp_b = food_r;
                if (len_r != '0) begin
                    // Segment 0 is requested here so its data lines up with the first SCAN cycle.
                    seg_rd_en = 1'b1;
                    state_nxt = SCAN;
                end else begin
                    state_nxt = DONE;
                end
            end
            SCAN: begin
                cmp_a = head_r;
                cmp_b = seg_data;
                if (cmp_eq) begin
                    // Early exit: a hit suppresses the next read.
                    self_set  = 1'b1;
                    state_nxt = DONE;
                end else if (idx_p1 < len_r) begin
                    seg_rd_en = 1'b1;
                    seg_addr  = idx_p1[ADDR_W-1:0];
                    idx_inc   = 1'b1;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus the sampled operands, scan index and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            head_r   <= 20'd0;
            food_r   <= 20'd0;
            len_r    <= '0;
            idx      <= '0;
            food_hit <= 1'b0;
            self_hit <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                head_r   <= head_pos;
                food_r   <= food_pos;
                len_r    <= (length > MAX_L) ? MAX_L : length;
                idx      <= '0;
                food_hit <= 1'b0;
                self_hit <= 1'b0;
            end else begin
                if (state == FOOD) begin
                    food_hit <= cmp_eq;
                end
                if (idx_inc) begin
                    idx <= idx_p1;
                end
                if (self_set) begin
                    self_hit <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_collision_scanner.sv
// Purpose: directed, table-driven check of the collision scanner against a 1-cycle-latency RAM model and a bench comparator.
// Latency: expected done cycles, read counts and flags are hand-computed constants in the vector table.
// Backpressure: covers start-during-done back-to-back acceptance and reset in the middle of a scan.
module tb_snake_collision_scanner;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] head_pos;
    logic [19:0] food_pos;
    logic [6:0]  length;
    logic [5:0]  seg_addr;
    logic        seg_rd_en;
    logic [19:0] seg_data;
    logic [19:0] cmp_a;
    logic [19:0] cmp_b;
    logic        cmp_eq;
    logic        busy;
    logic        done;
    logic        food_hit;
    logic        self_hit;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [19:0] ram [64];

    snake_collision_scanner #(.MAX_LEN(64), .ADDR_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .head_pos (head_pos),
        .food_pos (food_pos),
        .length   (length),
        .seg_addr (seg_addr),
        .seg_rd_en(seg_rd_en),
        .seg_data (seg_data),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .cmp_eq   (cmp_eq),
        .busy     (busy),
        .done     (done),
        .food_hit (food_hit),
        .self_hit (self_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared comparator and segment RAM with one cycle read latency.
    assign cmp_eq = (cmp_a == cmp_b);
    always @(posedge clk) begin
        if (seg_rd_en) seg_data <= ram[seg_addr];
    end

    typedef struct {
        logic [19:0] head;
        logic [19:0] food;
        logic [6:0]  len;
        int          hit;
        int          ef;
        int          es;
        int          dcyc;
        int          nrd;
        int          last;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Body segments all have bit 19 set, heads never do, so only the planted entry can match.
    task automatic fill_ram(input logic [19:0] h, input int hit, input int salt);
        for (int j = 0; j < 64; j++) ram[j] = {1'b1, 19'(j * 37 + salt)};
        if (hit >= 0) ram[hit] = h;
    endtask

    // Drives start for one cycle, then scrambles inputs; returns at the cycle-1 sample point.
    task automatic accept(input logic [19:0] h, input logic [19:0] f, input logic [6:0] l, input bit now);
        if (!now) @(negedge clk);
        head_pos = h;
        food_pos = f;
        length   = l;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        head_pos = ~h;
        food_pos = ~h;
        length   = 7'd3;
        @(negedge clk);
    endtask

    // Samples each cycle until done; checks read order and busy along the way.
    task automatic wait_done(output int cyc, output int nrd, output int last);
        cyc  = -1;
        nrd  = 0;
        last = -1;
        for (int c = 1; c <= 200; c++) begin
            if (seg_rd_en) begin
                chk("rd_order", int'(seg_addr), nrd);
                last = int'(seg_addr);
                nrd++;
            end
            if (done) begin
                cyc = c;
                return;
            end
            chk("busy_during_check", int'(busy), 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int nrd;
        int last;

        //               head        food        len    hit ef es dcyc nrd last
        vt[0] = '{20'h0A05A, 20'h0A05A, 7'd0,   -1, 1, 0, 2,  0,  -1};
        vt[1] = '{20'h12345, 20'h00001, 7'd5,   -1, 0, 0, 7,  5,  4};
        vt[2] = '{20'h0BEEF, 20'h00002, 7'd10,   3, 0, 1, 6,  4,  3};
        vt[3] = '{20'h01111, 20'h00003, 7'd100, -1, 0, 0, 66, 64, 63};
        vt[4] = '{20'h02222, 20'h02222, 7'd1,    0, 1, 1, 3,  1,  0};
        vt[5] = '{20'h03333, 20'h00004, 7'd64,  63, 0, 1, 66, 64, 63};
        vt[6] = '{20'h04444, 20'h04444, 7'd7,    6, 1, 1, 9,  7,  6};

        rst      = 1'b1;
        start    = 1'b0;
        head_pos = 20'd0;
        food_pos = 20'd0;
        length   = 7'd0;
        fill_ram(20'd0, -1, 0);
        repeat (2) @(negedge clk);
        chk("rst_flags", int'({busy, done, seg_rd_en, food_hit, self_hit}), 0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_rd_en", int'(seg_rd_en), 0);
            chk("idle_flags", int'({busy, done, food_hit, self_hit}), 0);
            chk("idle_cmp", int'(cmp_a | cmp_b), 0);
        end

        for (int i = 0; i < 7; i++) begin
            fill_ram(vt[i].head, vt[i].hit, i);
            accept(vt[i].head, vt[i].food, vt[i].len, 1'b0);
            wait_done(cyc, nrd, last);
            chk($sformatf("v%0d_done_cycle", i), cyc, vt[i].dcyc);
            chk($sformatf("v%0d_food_hit", i), int'(food_hit), vt[i].ef);
            chk($sformatf("v%0d_self_hit", i), int'(self_hit), vt[i].es);
            chk($sformatf("v%0d_reads", i), nrd, vt[i].nrd);
            chk($sformatf("v%0d_last_addr", i), last, vt[i].last);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), int'({done, busy}), 0);
            chk($sformatf("v%0d_hold", i), int'({food_hit, self_hit}), vt[i].ef * 2 + vt[i].es);
        end

        // Clamped scan with food hit, then start during the done cycle.
        fill_ram(20'h05555, -1, 11);
        accept(20'h05555, 20'h05555, 7'd100, 1'b0);
        wait_done(cyc, nrd, last);
        chk("b2b_first_done", cyc, 66);
        chk("b2b_first_food", int'(food_hit), 1);
        chk("b2b_first_reads", nrd, 64);
        accept(20'h06666, 20'h00005, 7'd0, 1'b1);
        chk("b2b_food_state", int'({busy, done}), 2);
        chk("b2b_flags_cleared", int'({food_hit, self_hit}), 0);
        wait_done(cyc, nrd, last);
        chk("b2b_second_done", cyc, 2);
        chk("b2b_second_food", int'(food_hit), 0);
        chk("b2b_second_reads", nrd, 0);

        // Reset at cycle 4 of a 10-segment scan.
        fill_ram(20'h07777, -1, 13);
        accept(20'h07777, 20'h07777, 7'd10, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_pre_food", int'(food_hit), 1);
        chk("mid_pre_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_flags", int'({busy, done, seg_rd_en, food_hit, self_hit}), 0);
        chk("mid_rst_cmp", int'(cmp_a | cmp_b), 0);
        chk("mid_rst_addr", int'(seg_addr), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_no_done", int'({done, seg_rd_en}), 0);
        end
        rst = 1'b0;
        fill_ram(20'h08888, 2, 17);
        accept(20'h08888, 20'h00006, 7'd4, 1'b0);
        wait_done(cyc, nrd, last);
        chk("fresh_done", cyc, 5);
        chk("fresh_self", int'(self_hit), 1);
        chk("fresh_food", int'(food_hit), 0);
        chk("fresh_reads", nrd, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
